// File: rtl/repl_plru_unit_if.sv
// Request/response bundle for the tree-PLRU replacement unit.
// Optional lock_mask exists only when REPL_LOCK_EN is defined.
interface repl_plru_unit_if #(
  parameter int WAYS = 4,
  parameter int SETS = 16
);
  localparam int SET_IDX = $clog2(SETS);
  localparam int WAY_IDX = $clog2(WAYS);

  logic               lookup_req;
  logic [SET_IDX-1:0] lookup_set;
  logic [WAYS-1:0]    valid_vec;
  logic               touch_en;
  logic [SET_IDX-1:0] touch_set;
  logic [WAYS-1:0]    touch_way;
`ifdef REPL_LOCK_EN
  logic [WAYS-1:0]    lock_mask;
`endif
  logic               flush_req;
  logic               ready;
  logic               evict_valid;
  logic [WAYS-1:0]    evict_way;
  logic [WAY_IDX-1:0] evict_idx;
  logic               evict_none;
  logic               flush_done;

  modport master (
`ifdef REPL_LOCK_EN
    output lock_mask,
`endif
    output lookup_req, lookup_set, valid_vec,
    output touch_en, touch_set, touch_way, flush_req,
    input  ready, evict_valid, evict_way, evict_idx, evict_none, flush_done
  );

  modport slave (
`ifdef REPL_LOCK_EN
    input  lock_mask,
`endif
    input  lookup_req, lookup_set, valid_vec,
    input  touch_en, touch_set, touch_way, flush_req,
    output ready, evict_valid, evict_way, evict_idx, evict_none, flush_done
  );
endinterface

// File: rtl/repl_plru_unit.sv
// Tree pseudo-LRU victim selector with per-set state and a flush sweep.
// Optional feature macro: REPL_LOCK_EN (adds lock_mask, evict_none can assert).
//
// state | meaning
// IDLE  | lookups/touches accepted, ready=1
// FLUSH | clearing one set per cycle, requests ignored
module repl_plru_unit #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input logic            clk,
  input logic            rst,
  repl_plru_unit_if.slave bus
);
  localparam int SET_IDX = $clog2(SETS);
  localparam int WAY_IDX = $clog2(WAYS);
  localparam int NODES   = WAYS - 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [SET_IDX-1:0] cnt_q;
  logic [NODES-1:0]   tree_q [SETS];

  logic               ready, flush_start, flush_last;
  logic               touch_ok, lookup_ok;
  logic [WAY_IDX-1:0] touch_idx, victim_idx;
  logic [NODES-1:0]   tree_touched, tree_lookup;
  logic [WAYS-1:0]    lock, avail;
  logic               victim_none;
  logic               evict_valid_q, flush_done_q;
  logic [WAYS-1:0]    evict_way_q;
  logic [WAY_IDX-1:0] evict_idx_q;

  // Point every node on the path to the accessed way away from it.
  function automatic logic [NODES-1:0] tree_touch(input logic [NODES-1:0] t,
                                                  input logic [WAY_IDX-1:0] way);
    logic [NODES-1:0] r;
    int node;
    r = t;
    node = 0;
    for (int l = WAY_IDX - 1; l >= 0; l--) begin
      r[node] = ~way[l];
      node = 2 * node + 1 + (way[l] ? 1 : 0);
    end
    return r;
  endfunction

  function automatic logic [WAY_IDX-1:0] oh_to_idx(input logic [WAYS-1:0] oh);
    logic [WAY_IDX-1:0] r;
    r = '0;
    for (int i = 0; i < WAYS; i++)
      if (oh[i]) r = WAY_IDX'(i);
    return r;
  endfunction

  function automatic logic range_locked(input logic [WAYS-1:0] lk, input int lo, input int cnt);
    logic hit;
    hit = 1'b1;
    for (int i = 0; i < WAYS; i++)
      if (i >= lo && i < lo + cnt && !lk[i]) hit = 1'b0;
    return hit;
  endfunction

  // Walk from the root; a fully locked chosen half diverts the walk to its sibling.
  function automatic logic [WAY_IDX-1:0] tree_walk(input logic [NODES-1:0] t,
                                                   input logic [WAYS-1:0] lk);
    int   node, base, half;
    logic dir;
    node = 0;
    base = 0;
    for (int l = 0; l < WAY_IDX; l++) begin
      half = WAYS >> (l + 1);
      dir  = t[node];
      if (!dir && range_locked(lk, base, half))            dir = 1'b1;
      else if (dir && range_locked(lk, base + half, half)) dir = 1'b0;
      if (dir) base = base + half;
      node = 2 * node + 1 + (dir ? 1 : 0);
    end
    return WAY_IDX'(base);
  endfunction

`ifdef REPL_LOCK_EN
  assign lock = bus.lock_mask;
`else
  assign lock = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state; flush wins over any same-cycle request.
  always_comb begin
    state_d     = state_q;
    ready       = 1'b0;
    flush_start = 1'b0;
    flush_last  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.flush_req) begin
          state_d     = FLUSH;
          flush_start = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == SET_IDX'(SETS - 1)) begin
          state_d    = IDLE;
          flush_last = 1'b1;
        end
      end
    endcase
  end

  // Request qualification and victim selection (lookup sees a same-set touch).
  always_comb begin
    touch_ok     = bus.touch_en & ready & ~bus.flush_req & $onehot(bus.touch_way);
    lookup_ok    = bus.lookup_req & ready & ~bus.flush_req;
    touch_idx    = oh_to_idx(bus.touch_way);
    tree_touched = tree_touch(tree_q[bus.touch_set], touch_idx);
    tree_lookup  = (touch_ok && bus.touch_set == bus.lookup_set) ? tree_touched
                                                                 : tree_q[bus.lookup_set];
    avail        = ~bus.valid_vec & ~lock;
    victim_none  = &lock;
    victim_idx   = tree_walk(tree_lookup, lock);
    if (|avail) begin
      victim_idx = '0;
      for (int i = WAYS - 1; i >= 0; i--)
        if (avail[i]) victim_idx = WAY_IDX'(i);
    end
  end

  // Flush sweep counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt_q <= '0;
    else if (flush_start)      cnt_q <= '0;
    else if (state_q == FLUSH) cnt_q <= cnt_q + 1'b1;
  end

  // Per-set tree bits: sweep clear or touch update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
    end else if (state_q == FLUSH) begin
      tree_q[cnt_q] <= '0;
    end else if (touch_ok) begin
      tree_q[bus.touch_set] <= tree_touched;
    end
  end

`ifdef REPL_LOCK_EN
  logic evict_none_q;
  // Registered "no evictable way" flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           evict_none_q <= 1'b0;
    else if (lookup_ok) evict_none_q <= victim_none;
  end
  assign bus.evict_none = evict_none_q;
`else
  assign bus.evict_none = 1'b0;
`endif

  // Registered victim response, one cycle after an accepted lookup.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evict_valid_q <= 1'b0;
      evict_way_q   <= '0;
      evict_idx_q   <= '0;
      flush_done_q  <= 1'b0;
    end else begin
      evict_valid_q <= lookup_ok;
      flush_done_q  <= flush_last;
      if (lookup_ok) begin
        evict_idx_q <= victim_none ? '0 : victim_idx;
        evict_way_q <= victim_none ? '0 : (WAYS'(1) << victim_idx);
      end
    end
  end

  assign bus.ready       = ready;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_way   = evict_way_q;
  assign bus.evict_idx   = evict_idx_q;
  assign bus.flush_done  = flush_done_q;
endmodule

// File: doc/repl_plru_unit.md
REPL_PLRU_UNIT -- requirements
Module: repl_plru_unit

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, 2..16.
REQ-002 SHALL have parameter SETS, default 16, set count; power of two, 2..64; SET_IDX = log2(SETS), WAY_IDX = log2(WAYS).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port lookup_req  input  1  request a victim for lookup_set.
REQ-006 SHALL have port lookup_set  input  SET_IDX  set index of the lookup.
REQ-007 SHALL have port valid_vec  input  WAYS  per-way valid bits of lookup_set.
REQ-008 SHALL have port touch_en  input  1  record an access.
REQ-009 SHALL have port touch_set  input  SET_IDX  set index of the access.
REQ-010 SHALL have port touch_way  input  WAYS  one-hot accessed way.
REQ-011 SHALL have port lock_mask  input  WAYS  ways excluded from eviction; present only with REPL_LOCK_EN.
REQ-012 SHALL have port flush_req  input  1  start a sweep clearing all set state.
REQ-013 SHALL have port ready  output  1  high when lookups and touches are accepted.
REQ-014 SHALL have port evict_valid  output  1  victim response valid.
REQ-015 SHALL have port evict_way  output  WAYS  one-hot victim.
REQ-016 SHALL have port evict_idx  output  WAY_IDX  binary victim index.
REQ-017 SHALL have port evict_none  output  1  no evictable way (all locked).
REQ-018 SHALL have port flush_done  output  1  single-cycle pulse at sweep end.

Function
REQ-019 SHALL keep WAYS-1 tree bits per set; node 0 is the root; children of node n are 2n+1 (lower half) and 2n+2 (upper half).
REQ-020 Node bit 0 SHALL steer the victim walk to the lower half; 1 SHALL steer it to the upper half.
REQ-021 On an accepted touch (touch_en & ready), every node on the path to touch_way SHALL be set to point away from it at the next edge; off-path nodes SHALL hold.
REQ-022 touch_way with zero or more than one bit set SHALL leave state unchanged.
REQ-023 A lookup accepted in cycle N SHALL produce evict_valid=1 and registered victim outputs in cycle N+1 only; latency SHALL be exactly 1.
REQ-024 If touch and lookup hit the same set in cycle N, the lookup SHALL use the post-touch state (bypass).
REQ-025 If any valid_vec bit is 0, the victim SHALL be the lowest-index invalid way, overriding the tree.
REQ-026 Otherwise the victim SHALL be the leaf reached by walking the tree from the root.
REQ-027 evict_way SHALL always be one-hot and consistent with evict_idx whenever evict_valid=1 and evict_none=0.
REQ-028 FSM states SHALL be IDLE and FLUSH; ready=1 only in IDLE.
REQ-029 flush_req in IDLE SHALL enter FLUSH; a counter from 0 SHALL clear one set per cycle, SETS cycles in total.
REQ-030 After clearing set SETS-1 the FSM SHALL return to IDLE and pulse flush_done for exactly one cycle.
REQ-031 In FLUSH, lookup_req, touch_en and flush_req SHALL be ignored and evict_valid SHALL stay 0.
REQ-032 flush_req together with touch_en or lookup_req in IDLE SHALL give flush priority; the touch and lookup SHALL be dropped.

Reset
REQ-033 Asserting rst SHALL immediately clear all tree bits, enter IDLE, and zero the counter, evict_valid, evict_way, evict_idx, evict_none and flush_done.
REQ-034 ready SHALL be 1 during and after reset.
REQ-035 A reset during FLUSH SHALL abort the sweep with no flush_done pulse.

Configuration
REQ-036 With macro REPL_LOCK_EN defined, lock_mask SHALL exist, and locked ways SHALL be removed from both invalid-first and tree selection.
REQ-037 With REPL_LOCK_EN, at any node whose chosen subtree is fully locked, the walk SHALL take the other subtree.
REQ-038 With REPL_LOCK_EN, if all ways are locked, the response SHALL be evict_none=1, evict_way=0 and evict_idx=0.
REQ-039 Without REPL_LOCK_EN, lock_mask SHALL be absent and evict_none SHALL be tied to 0.

Verification
REQ-040 WAYS=4, after reset: lookup set 3 with valid_vec=1111 -> next cycle evict_idx=0, evict_way=0001.
REQ-041 WAYS=4: touch set 3 way 0001, then lookup set 3 with valid 1111 -> evict_idx=2; touch way 0100, then lookup -> evict_idx=1.
REQ-042 Same-cycle touch set 5 way 0001 and lookup set 5 (valid 1111) -> evict_idx=2 (bypass); set 6 unaffected -> evict_idx=0.
REQ-043 Lookup with valid_vec=1011 after arbitrary touches -> evict_idx=2.
REQ-044 SETS=16: touches to sets 0..15, flush_req -> ready=0 for 16 cycles, flush_done pulses once, all sets then give evict_idx=0; rst at flush cycle 5 -> no flush_done pulse.
REQ-045 REPL_LOCK_EN, WAYS=4, reset state, lock_mask=0011 -> evict_idx=2; lock_mask=1111 -> evict_none=1.
